// File: rtl/fa_32bit.sv
// Registered N-bit ripple-carry adder: a chain of 1-bit full-adder cells feeding
// an output register, giving {cout, s} = a + b + cin with one clock of latency.

`timescale 1ns/100ps

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module fa_32bit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0]   c;
  logic [N-1:0] sum;

  assign c[0] = cin;

  // Carry ripples from bit 0 upward; c[N] is the overflow out of the chain.
  for (genvar i = 0; i < N; i++) begin : gen_cell
    fa_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of the combinational chain, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= sum;
      cout <= c[N];
    end
  end

endmodule

// File: tb/tb_fa_32bit.sv
// Directed-vector bench for fa_32bit at N = 4: reset behaviour, latency,
// lockstep sweep, carry-ripple corners and asynchronous reset mid-operation.

`timescale 1ns/100ps

module tb_fa_32bit;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] s;
  logic         cout;

  int n_cmp = 0;
  int n_err = 0;

  fa_32bit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .cout  (cout)
  );

  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [N:0] got, input logic [N:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {cout,s}=%h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc);
    a   = ta;
    b   = tb;
    cin = tc;
  endtask

  // Drive on a falling edge, let one rising edge capture, check on the next falling edge.
  task automatic step_check(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                            input logic tc, input logic [N:0] exp);
    @(negedge clk);
    drive(ta, tb, tc);
    @(negedge clk);
    check(tag, {cout, s}, exp);
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N:0]   exp;
  } vec_t;

  vec_t post_rst_vecs[5];

  initial begin
    // Hand-computed {cout, s} for vectors applied after the mid-operation reset.
    post_rst_vecs[0] = '{a: 4'h1, b: 4'h2, cin: 1'b1, exp: 5'h04};
    post_rst_vecs[1] = '{a: 4'h8, b: 4'h8, cin: 1'b0, exp: 5'h10};
    post_rst_vecs[2] = '{a: 4'h7, b: 4'h9, cin: 1'b1, exp: 5'h11};
    post_rst_vecs[3] = '{a: 4'hC, b: 4'h3, cin: 1'b0, exp: 5'h0F};
    post_rst_vecs[4] = '{a: 4'h6, b: 4'h5, cin: 1'b1, exp: 5'h0C};

    // 1: held in reset while inputs toggle; outputs stay zero.
    rst_n = 1'b0;
    drive(4'hF, 4'hF, 1'b1);
    #0.5;
    check("reset_initial", {cout, s}, 5'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(4'(i * 5 + 3), 4'(15 - i * 3), 1'(i));
      @(negedge clk);
      check($sformatf("reset_hold_%0d", i), {cout, s}, 5'h00);
    end

    // 2: release reset with 3 + 4 applied; result only after the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'h3, 4'h4, 1'b0);
    #0.5;
    check("pre_edge_absent", {cout, s}, 5'h00);
    @(negedge clk);
    check("first_result_3p4", {cout, s}, 5'h07);

    // 3: lockstep sweep a = b = 0..15, each held 10 time units.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(4'(i), 4'(i), 1'b0);
      repeat (5) @(negedge clk);
      check($sformatf("sweep_%0d", i), {cout, s}, {1'(i >= 8), 4'((2 * i) % 16)});
    end
    step_check("sweep_9_direct", 4'h9, 4'h9, 1'b0, 5'h12);

    // 4: full carry ripple through every cell.
    step_check("ripple_F_0_1", 4'hF, 4'h0, 1'b1, 5'h10);

    // 5: maximum case, then a no-carry all-ones sum.
    step_check("max_F_F_1", 4'hF, 4'hF, 1'b1, 5'h1F);
    step_check("5_A_0", 4'h5, 4'hA, 1'b0, 5'h0F);

    // 6: reset asserted between edges while s = 4'hA clears outputs without a clock.
    step_check("pre_reset_A", 4'h5, 4'h5, 1'b0, 5'h0A);
    #0.5;
    rst_n = 1'b0;
    #0.1;
    check("async_clear", {cout, s}, 5'h00);
    @(negedge clk);
    check("reset_through_edge", {cout, s}, 5'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step_check($sformatf("post_reset_%0d", i), post_rst_vecs[i].a, post_rst_vecs[i].b,
                 post_rst_vecs[i].cin, post_rst_vecs[i].exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
